// File: rtl/eta_bit_pack.sv
// Packs signed eta-bounded coefficients into a byte stream (FIPS 204 BitPack, LSB-first).
// Optional macro ETA4_EN adds the eta_sel port (0: eta=2, W=3; 1: eta=4, W=4).
module eta_bit_pack (
  input  logic       clk,
  input  logic       rst_n,
`ifdef ETA4_EN
  input  logic       eta_sel,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_coeff,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic       coeff_err
);

  localparam int unsigned ACC_W  = 16;
  localparam int unsigned FILL_W = 5;
  localparam int unsigned CCNT_W = 8;
  localparam int unsigned BCNT_W = 7;

  logic [2:0]        w;
  logic [3:0]        eta;
  logic [BCNT_W-1:0] last_idx;

`ifdef ETA4_EN
  assign w        = eta_sel ? 3'd4 : 3'd3;
  assign eta      = eta_sel ? 4'd4 : 4'd2;
  assign last_idx = eta_sel ? BCNT_W'(127) : BCNT_W'(95);
`else
  assign w        = 3'd3;
  assign eta      = 4'd2;
  assign last_idx = BCNT_W'(95);
`endif

  logic [ACC_W-1:0]  acc, acc_base, acc_nxt;
  logic [FILL_W-1:0] fill, fill_base, fill_nxt;
  logic [CCNT_W-1:0] coeff_cnt;
  logic [BCNT_W-1:0] byte_cnt;
  logic signed [4:0] coeff_s, eta_s;
  logic [3:0]        v_raw, v_field;
  logic              accept, xfer, out_of_range;

  // Field value eta - c; only the low W bits are packed, so 4-bit wraparound is sufficient.
  assign v_raw        = eta - in_coeff;
  assign v_field      = (w == 3'd4) ? v_raw : {1'b0, v_raw[2:0]};
  assign coeff_s      = {in_coeff[3], in_coeff};
  assign eta_s        = signed'({1'b0, eta});
  assign out_of_range = (coeff_s > eta_s) || (coeff_s < -eta_s);

  assign in_ready = (fill <= (FILL_W'(ACC_W) - FILL_W'(w)));
  assign accept   = in_valid & in_ready;
  assign xfer     = (fill >= FILL_W'(8)) && (!out_valid || out_ready);

  // Drain a byte first, then land the new field above whatever bits remain.
  always_comb begin
    acc_base  = acc;
    fill_base = fill;
    if (xfer) begin
      acc_base  = acc >> 8;
      fill_base = fill - FILL_W'(8);
    end
    acc_nxt  = acc_base;
    fill_nxt = fill_base;
    if (accept) begin
      acc_nxt  = acc_base | (ACC_W'(v_field) << fill_base);
      fill_nxt = fill_base + FILL_W'(w);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      fill      <= '0;
      coeff_cnt <= '0;
      byte_cnt  <= '0;
      out_valid <= 1'b0;
      out_byte  <= '0;
      out_last  <= 1'b0;
      coeff_err <= 1'b0;
    end else begin
      acc  <= acc_nxt;
      fill <= fill_nxt;
      if (accept) begin
        coeff_cnt <= coeff_cnt + CCNT_W'(1);
        if (out_of_range) coeff_err <= 1'b1;
      end
      if (xfer) begin
        out_valid <= 1'b1;
        out_byte  <= acc[7:0];
        out_last  <= (byte_cnt == last_idx);
        byte_cnt  <= (byte_cnt == last_idx) ? '0 : byte_cnt + BCNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eta_bit_pack.sv
// Self-checking bench for eta_bit_pack: vector table, directed corner sequences and
// randomized streams compared against a bit-level BitPack reference model.
module tb_eta_bit_pack;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_coeff;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;
  logic       coeff_err;
`ifdef ETA4_EN
  logic       eta_sel;
`endif

  eta_bit_pack dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ETA4_EN
    .eta_sel   (eta_sel),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coeff  (in_coeff),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .coeff_err (coeff_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] coeffs;  // coefficient i in nibble i
    logic [23:0] bytes;   // byte k in bits [8k +: 8]
  } vec_t;

  vec_t       tbl [7];
  int         n_tests, n_fail;
  int         tx_q[$];
  int         sent[$];
  logic [7:0] rx_byte[$];
  logic       rx_last[$];
  int         stall, accepted;
  bit         rand_ready, hold_chk;
  logic [7:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One clock of bench activity, on the falling edge.
  task automatic step();
    @(negedge clk);
    if (hold_chk) check("stall_hold", {23'd0, out_valid, out_byte}, {23'd0, 1'b1, held});
    if (stall > 0) begin
      out_ready = 1'b0;
      stall--;
    end else if (rand_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
    if (out_valid && out_ready) begin
      rx_byte.push_back(out_byte);
      rx_last.push_back(out_last);
    end
    hold_chk = out_valid && !out_ready;
    held     = out_byte;
    if (tx_q.size() > 0) begin
      in_valid = 1'b1;
      in_coeff = 4'(tx_q[0]);
      if (in_ready) begin
        void'(tx_q.pop_front());
        accepted++;
      end
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic push(input int c);
    tx_q.push_back(c);
    sent.push_back(c);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    hold_chk   = 1'b0;
    stall      = 0;
    rand_ready = 1'b0;
    accepted   = 0;
    tx_q.delete();
    sent.delete();
    rx_byte.delete();
    rx_last.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_rx(input int n);
    int c = 0;
    while (rx_byte.size() < n && c < 5000) begin
      step();
      c++;
    end
    check("rx_count", rx_byte.size(), n);
  endtask

  // Stream bit k belongs to coefficient k/W at bit k%W of ((eta - c) mod 2^W).
  function automatic logic [7:0] model_byte(input int j, input int w, input int eta);
    logic [7:0] b = 8'h00;
    for (int k = 0; k < 8; k++) begin
      int pos = 8 * j + k;
      int v   = (eta - sent[pos / w]) & ((1 << w) - 1);
      b[k] = 1'((v >> (pos % w)) & 1);
    end
    return b;
  endfunction

  task automatic compare_stream(input string name, input int w, input int eta);
    int nb = sent.size() * w / 8;
    wait_rx(nb);
    for (int j = 0; j < nb; j++) begin
      check($sformatf("%s_byte%0d", name, j), rx_byte[j], model_byte(j, w, eta));
      check($sformatf("%s_last%0d", name, j), rx_last[j], ((j % (32 * w)) == 32 * w - 1));
    end
  endtask

  function automatic int rand_coeff(input int eta);
    return int'($urandom_range(0, 2 * eta)) - eta;
  endfunction

  initial begin
    int cyc;
    bit err_exp;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    in_valid = 1'b0;
    in_coeff = 4'h0;
    out_ready = 1'b0;
    stall = 0;
    rand_ready = 1'b0;
    hold_chk = 1'b0;
    accepted = 0;
`ifdef ETA4_EN
    eta_sel = 1'b0;
`endif
    tbl[0] = '{coeffs: 32'h012EF012, bytes: 24'h444688};
    tbl[1] = '{coeffs: 32'hEEEEEEEE, bytes: 24'h924924};
    tbl[2] = '{coeffs: 32'h22222222, bytes: 24'h000000};
    tbl[3] = '{coeffs: 32'h00000000, bytes: 24'h492492};
    tbl[4] = '{coeffs: 32'hFFFFFFFF, bytes: 24'h6DB6DB};
    tbl[5] = '{coeffs: 32'h11111111, bytes: 24'h249249};
    tbl[6] = '{coeffs: 32'h0FE210FE, bytes: 24'h4E029C};

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_byte", out_byte, 0);
    check("rst_coeff_err", coeff_err, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed vectors, eta=2: 8 coefficients -> 3 bytes each.
    for (int e = 0; e < 7; e++) begin
      rx_byte.delete();
      rx_last.delete();
      for (int i = 0; i < 8; i++) begin
        logic signed [3:0] s;
        s = tbl[e].coeffs[4*i +: 4];
        push(int'(s));
      end
      wait_rx(3);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("tbl%0d_byte%0d", e, k), rx_byte[k], tbl[e].bytes[8*k +: 8]);
        check($sformatf("tbl%0d_last%0d", e, k), rx_last[k], 0);
      end
    end

    // Two polynomials of -2, full rate.
    apply_reset();
    for (int i = 0; i < 512; i++) push(-2);
    cyc = 0;
    while (tx_q.size() > 0 && cyc < 2000) begin
      step();
      cyc++;
    end
    check("throughput_cycles", cyc, 512);
    compare_stream("all_m2", 3, 2);
    check("all_m2_last95", rx_last[95], 1);
    check("all_m2_last191", rx_last[191], 1);

    // Sticky error flag.
    apply_reset();
    check("err_after_rst", coeff_err, 0);
    push(3);
    cyc = 0;
    while (accepted < 1 && cyc < 50) begin
      step();
      cyc++;
    end
    check("err_before_edge", coeff_err, 0);
    step();
    check("err_set", coeff_err, 1);
    for (int i = 0; i < 15; i++) push(rand_coeff(2));
    wait_rx(6);
    check("err_held", coeff_err, 1);
    check("err_pack_byte0", rx_byte[0], model_byte(0, 3, 2));
    apply_reset();
    check("err_cleared", coeff_err, 0);

    // Output stall with continuous input.
    for (int i = 0; i < 96; i++) push(rand_coeff(2));
    repeat (6) step();
    stall = 20;
    repeat (20) step();
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    compare_stream("stall", 3, 2);

    // Random backpressure, occasional out-of-range coefficients.
    apply_reset();
    rand_ready = 1'b1;
    err_exp = 1'b0;
    for (int i = 0; i < 512; i++) begin
      int c = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15)) - 8 : rand_coeff(2);
      if (c < -2 || c > 2) err_exp = 1'b1;
      push(c);
    end
    compare_stream("rand", 3, 2);
    check("rand_coeff_err", coeff_err, 32'(err_exp));

    // Reset in the middle of a polynomial.
    apply_reset();
    push(3);
    for (int i = 0; i < 99; i++) push(rand_coeff(2));
    repeat (40) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_coeff_err", coeff_err, 0);
    check("midrst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    hold_chk = 1'b0;
    tx_q.delete();
    sent.delete();
    rx_byte.delete();
    rx_last.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) push(rand_coeff(2));
    compare_stream("post_rst", 3, 2);
    check("post_rst_err", coeff_err, 0);

`ifdef ETA4_EN
    apply_reset();
    eta_sel = 1'b1;
    push(4);
    push(-4);
    wait_rx(1);
    check("eta4_first", rx_byte[0], 8'h80);
    for (int i = 0; i < 254; i++) push(rand_coeff(4));
    compare_stream("eta4", 4, 4);
    check("eta4_last127", rx_last[127], 1);
    check("eta4_err", coeff_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eta_bit_pack.md
ETA_BIT_PACK -- requirements
Module: eta_bit_pack

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, rising-edge; rst_n  input  1  asynchronous, active-low reset.
REQ-002 SHALL have ports: in_valid  input  1  coefficient offered; in_ready  output  1  coefficient accepted this cycle when in_valid=1; in_coeff  input  4  signed coefficient, two's complement.
REQ-003 SHALL have ports: out_valid  output  1  byte available; out_ready  input  1  consumer takes byte; out_byte  output  8  packed byte; out_last  output  1  final byte of a polynomial.
REQ-004 SHALL have port: coeff_err  output  1  sticky flag, out-of-range coefficient seen.
REQ-005 SHALL have port eta_sel  input  1  (0: eta=2, 1: eta=4) only when ETA4_EN is defined.

Function
REQ-006 SHALL pack per FIPS 204 BitPack(w, eta, eta): value v = eta - c, field width W=3 (eta=2) or W=4 (eta=4).
REQ-007 SHALL order bits LSB-first: coefficient i occupies stream bits [W*i +: W]; byte j = stream bits [8j +: 8].
REQ-008 SHALL hold a 16-bit accumulator acc and a 5-bit fill count; accept = in_valid & in_ready; in_ready = (fill <= 16-W), independent of out_ready.
REQ-009 On accept, SHALL place v at acc[fill +: W] and add W to fill.
REQ-010 SHALL transfer acc[7:0] to the output register when fill >= 8 and (out_valid=0 or out_ready=1); acc shifts right 8 and fill decreases by 8 on the same edge.
REQ-011 Accept and transfer in the same cycle SHALL both take effect; the new field lands at position fill-8.
REQ-012 out_valid/out_byte/out_last SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-013 Latency SHALL be 1 cycle from the edge where fill reaches >= 8 to out_valid=1, given a free output register.
REQ-014 SHALL count accepted coefficients 0..255 and emitted bytes 0..32W-1; out_last=1 exactly with byte 32W-1 (95 for eta=2, 127 for eta=4).
REQ-015 Both counters SHALL wrap to 0 after the last item; no residual bits remain since 256*W is a multiple of 8.
REQ-016 Throughput SHALL sustain one coefficient per cycle when out_ready=1 continuously.
REQ-017 coeff_err SHALL set on accept of c < -eta or c > eta and stay set until reset; the low W bits of v are packed regardless.

Reset
REQ-018 rst_n=0 SHALL asynchronously clear acc, fill, both counters, out_valid, out_byte, out_last and coeff_err to 0; in_ready SHALL read 1 while held in reset.
REQ-019 Reset mid-polynomial SHALL discard all partial bits; the next accepted coefficient is coefficient 0.

Configuration
REQ-020 Macro ETA4_EN: defined -> eta_sel port present, W and the last-byte index follow eta_sel.
REQ-021 ETA4_EN undefined -> no eta_sel port, fixed eta=2, W=3, 96 bytes per polynomial.
REQ-022 eta_sel SHALL change only when fill=0 and the coefficient counter is 0; behaviour otherwise is undefined.

Verification
REQ-023 Reset asserted mid-stream -> out_valid=0, out_last=0, coeff_err=0, in_ready=1 immediately.
REQ-024 eta=2, out_ready=1, coeffs 2,1,0,-1,-2,2,1,0 -> bytes 0x88,0x46,0x44 in order.
REQ-025 eta=2, 256 coeffs all -2 -> 96 bytes repeating 0x24,0x49,0x92; out_last=1 only on byte 96; a second polynomial repeats identically.
REQ-026 Continuous input, out_ready=0 for 20 cycles, then 1 -> in_ready drops once fill > 13; no byte lost or reordered; out_byte is stable while stalled.
REQ-027 eta=2, coeff 3 accepted -> coeff_err=1 on the next cycle and held through later valid coefficients until rst_n=0.
REQ-028 ETA4_EN, eta_sel=1, coeffs 4,-4 -> byte 0x80; 256 coeffs -> out_last on byte 128.
